// File: rtl/wb_pkg.sv
// Shared widths, the hard-wired zero register index and the writeback request record.
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_X0_INDEX   = 0;

    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] address;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a remembered last winner.
// Latency: grant is combinational from req; last_grant moves on the cycle after advance.
// Backpressure: a losing request is simply not granted and must be held by its owner.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges execute and memory writebacks onto the single register-file write port.
// Latency: one cycle from accepted request to wr_enable/rd_*.
// Backpressure: ready is combinational; the loser holds its request, nothing is buffered.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  grant_id
);

    logic [1:0]            grant;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter2 u_rr_arbiter2 (
        .clock   (clock),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (transfer),
        .grant   (grant)
    );

    // Reset masks ready so a pending request can never complete during reset.
    assign req0_ready  = grant[0] & ~reset;
    assign req1_ready  = grant[1] & ~reset;
    assign transfer    = req0_ready | req1_ready;
    assign sel_address = req1_ready ? req1_address : req0_address;
    assign sel_data    = req1_ready ? req1_data    : req0_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_enable  <= 1'b0;
            rd_address <= '0;
            rd_data    <= '0;
            grant_id   <= 1'b0;
        end else if (transfer) begin
            // x0 is hard-wired zero: accept the write but suppress the strobe.
            wr_enable  <= (sel_address != ADDR_WIDTH'(WB_X0_INDEX));
            rd_address <= sel_address;
            rd_data    <= sel_data;
            grant_id   <= req1_ready;
        end else begin
            wr_enable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic                     clock;
    logic                     reset;
    wb_req_t                  r0;
    wb_req_t                  r1;
    logic                     req0_ready;
    logic                     req1_ready;
    logic                     wr_enable;
    logic [WB_ADDR_WIDTH-1:0] rd_address;
    logic [WB_DATA_WIDTH-1:0] rd_data;
    logic                     grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.DATA_WIDTH(WB_DATA_WIDTH), .ADDR_WIDTH(WB_ADDR_WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (r0.valid),
        .req0_address (r0.address),
        .req0_data    (r0.data),
        .req0_ready   (req0_ready),
        .req1_valid   (r1.valid),
        .req1_address (r1.address),
        .req1_data    (r1.data),
        .req1_ready   (req1_ready),
        .wr_enable    (wr_enable),
        .rd_address   (rd_address),
        .rd_data      (rd_data),
        .grant_id     (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [63:0] addr,
                             input logic [63:0] data, input logic gid);
        check_eq({tag, ".wr_enable"}, 64'(wr_enable), 64'(we));
        check_eq({tag, ".rd_address"}, 64'(rd_address), addr);
        check_eq({tag, ".rd_data"}, 64'(rd_data), data);
        check_eq({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
    endtask

    task automatic check_rdy(input string tag, input logic rdy0, input logic rdy1);
        #1;
        check_eq({tag, ".req0_ready"}, 64'(req0_ready), 64'(rdy0));
        check_eq({tag, ".req1_ready"}, 64'(req1_ready), 64'(rdy1));
    endtask

    initial begin
        logic k_is_one;
        reset = 1'b1;
        r0 = '{valid: 1'b1, address: 5'd3, data: 32'hA000_0003};
        r1 = '{valid: 1'b1, address: 5'd4, data: 32'hB000_0004};

        // Reset held three cycles with both requesters pending.
        for (int i = 0; i < 3; i++) begin
            step();
            check_rdy("rst_hold", 1'b0, 1'b0);
            check_out("rst_hold", 1'b0, 64'd0, 64'd0, 1'b0);
        end

        // Continuous contention: grants alternate starting with requester 0.
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            k_is_one = (k % 2) == 1;
            check_rdy($sformatf("rr%0d", k), !k_is_one, k_is_one);
            step();
            if (k_is_one) check_out($sformatf("rr%0d", k), 1'b1, 64'd4, 64'hB000_0004, 1'b1);
            else          check_out($sformatf("rr%0d", k), 1'b1, 64'd3, 64'hA000_0003, 1'b0);
        end

        // Idle cycle: no ready, strobe drops, write port holds.
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        check_rdy("idle", 1'b0, 1'b0);
        step();
        check_out("idle", 1'b0, 64'd4, 64'hB000_0004, 1'b1);

        // Lone requester 1 is accepted in the same cycle.
        r1 = '{valid: 1'b1, address: 5'd7, data: 32'hDEAD_BEEF};
        check_rdy("solo1", 1'b0, 1'b1);
        step();
        check_out("solo1", 1'b1, 64'd7, 64'hDEAD_BEEF, 1'b1);

        // Requester 1 just won, so contention goes to requester 0 then back to 1.
        r0 = '{valid: 1'b1, address: 5'd3, data: 32'h0000_0033};
        r1 = '{valid: 1'b1, address: 5'd4, data: 32'h0000_0044};
        check_rdy("after1_a", 1'b1, 1'b0);
        step();
        check_out("after1_a", 1'b1, 64'd3, 64'h33, 1'b0);
        check_rdy("after1_b", 1'b0, 1'b1);
        step();
        check_out("after1_b", 1'b1, 64'd4, 64'h44, 1'b1);

        // Write to x0 is accepted but produces no strobe.
        r0 = '{valid: 1'b1, address: 5'd0, data: 32'h1234_5678};
        r1.valid = 1'b0;
        check_rdy("x0", 1'b1, 1'b0);
        step();
        check_out("x0", 1'b0, 64'd0, 64'h1234_5678, 1'b0);

        // last_grant is now 0; reset during a would-be transfer discards it and restores last_grant=1.
        r1 = '{valid: 1'b1, address: 5'd9, data: 32'h0000_0099};
        r0 = '{valid: 1'b1, address: 5'd8, data: 32'h0000_0088};
        reset = 1'b1;
        check_rdy("rst_mid", 1'b0, 1'b0);
        step();
        check_out("rst_mid", 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b0;
        check_rdy("post_rst", 1'b1, 1'b0);
        step();
        check_out("post_rst", 1'b1, 64'd8, 64'h88, 1'b0);

        r0.valid = 1'b0;
        r1.valid = 1'b0;
        step();
        check_eq("final.wr_enable", 64'(wr_enable), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req0_valid  input  1  execute-unit writeback request (requester 0).
REQ-007 req0_address  input  ADDR_WIDTH  destination register of requester 0.
REQ-008 req0_data  input  DATA_WIDTH  write data of requester 0.
REQ-009 req0_ready  output  1  requester 0 accepted this cycle.
REQ-010 req1_valid, req1_address, req1_data, req1_ready SHALL mirror REQ-006..009 for the memory-unit writeback (requester 1).
REQ-011 wr_enable  output  1  register-file write strobe.
REQ-012 rd_address  output  ADDR_WIDTH  register-file write index.
REQ-013 rd_data  output  DATA_WIDTH  register-file write data.
REQ-014 grant_id  output  1  requester whose write is on rd_* this cycle.

Function
REQ-015 Handshake SHALL be valid/ready; transfer occurs when reqN_valid and reqN_ready are both high at a posedge.
REQ-016 At most one of req0_ready/req1_ready SHALL be high in any cycle.
REQ-017 reqN_ready SHALL be combinational from reqN_valid and arbiter state; ready SHALL never be high while the matching valid is low.
REQ-018 One valid only: that requester SHALL be granted the same cycle.
REQ-019 Both valid: the requester not granted most recently (last_grant) SHALL be granted (round-robin).
REQ-020 last_grant SHALL update to the granted requester on each transfer; it SHALL hold when no transfer occurs.
REQ-021 Output stage SHALL be registered: a transfer at edge N SHALL drive wr_enable, rd_address, rd_data, grant_id during cycle N to N+1 (1-cycle latency).
REQ-022 A transfer with address 0 SHALL be accepted (ready high) but SHALL produce wr_enable=0; rd_address/rd_data SHALL still load.
REQ-023 No transfer at an edge: wr_enable SHALL be 0 next cycle; rd_address, rd_data, grant_id SHALL hold.
REQ-024 Throughput SHALL be one write per cycle sustained; with both valid continuously, grants SHALL alternate 0,1,0,1.
REQ-025 A waiting requester SHALL be granted within 2 cycles of asserting valid (starvation bound).
REQ-026 Requesters SHALL hold valid/address/data stable until accepted; the block SHALL not buffer un-accepted requests.

Reset
REQ-027 While reset is high: wr_enable=0, rd_address=0, rd_data=0, grant_id=0, req0_ready=0, req1_ready=0.
REQ-028 Reset SHALL set last_grant=1 so requester 0 wins the first contention.
REQ-029 Reset asserted with a request pending SHALL discard it (no write after reset release) and take priority over any simultaneous transfer.

Structure
REQ-030 A shared package wb_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the x0 index constant, and typedef wb_req_t {valid, address, data}.
REQ-031 Grant logic SHALL be a sub-module rr_arbiter2 (two requests in, one-hot grant out, internal last_grant, advance input).
REQ-032 wr_enable/rd_address/rd_data SHALL connect directly to the register-file write port, which is the only consumer.

Verification
REQ-033 Reset held 3 cycles with both valid high -> both ready 0, wr_enable 0 throughout; first contention after release grants req0.
REQ-034 Only req1_valid, address 7, data 0xDEADBEEF -> req1_ready same cycle; next cycle wr_enable=1, rd_address=7, rd_data=0xDEADBEEF, grant_id=1.
REQ-035 Both valid for 6 cycles, addresses 3 and 4 -> grant sequence 0,1,0,1,0,1; writes to 3,4,3,4,3,4 on consecutive cycles.
REQ-036 req0 address 0, data 0x12345678 -> req0_ready=1, next-cycle wr_enable=0.
REQ-037 req1 granted, then both valid -> req0 granted next; req1 waits at most 1 cycle.
REQ-038 Reset asserted in the cycle a transfer would occur -> no write is issued and last_grant returns to 1.
